// File: rtl/rvfpm_commit_scoreboard_pkg.sv
// Shared types and sizing constants for the FPU commit scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pa_rvfpm;

    // Default number of in-flight entries and XIF id width.
    localparam int SCB_QUEUE_DEPTH = 4;
    localparam int SCB_ID_W        = 4;

    // Head/tail pointers carry one extra bit so full and empty can be told apart.
    localparam int SCB_PTR_W = $clog2(SCB_QUEUE_DEPTH) + 1;

    // One tracked instruction. The id field is SCB_ID_W wide; the scoreboard
    // casts to and from its X_ID_WIDTH parameter.
    typedef struct packed {
        logic                valid;
        logic                committed;
        logic                killed;
        logic [SCB_ID_W-1:0] id;
        logic [31:0]         instr;
    } scb_entry_t;

endpackage

// File: rtl/rvfpm_commit_scoreboard_if.sv
// Issue/commit/dispatch bundle between the XIF front end and the FPU scoreboard.
// Latency: n/a (wires only).
// Backpressure: alloc_valid/alloc_ready and dispatch_valid/dispatch_ready handshakes.
interface rvfpm_commit_scoreboard_if #(
    parameter int X_ID_WIDTH = 4
);
    logic                  alloc_valid;
    logic                  alloc_ready;
    logic [X_ID_WIDTH-1:0] alloc_id;
    logic [31:0]           alloc_instr;

    logic                  commit_valid;
    logic [X_ID_WIDTH-1:0] commit_id;
    logic                  commit_kill;

    logic                  dispatch_valid;
    logic                  dispatch_ready;
    logic [X_ID_WIDTH-1:0] dispatch_id;
    logic [31:0]           dispatch_instr;

    logic                  drop_valid;
    logic [X_ID_WIDTH-1:0] drop_id;
    logic                  commit_miss;

    // Core / issue side: offers instructions and commits, accepts dispatches.
    modport master (
        output alloc_valid, alloc_id, alloc_instr,
        output commit_valid, commit_id, commit_kill,
        output dispatch_ready,
        input  alloc_ready,
        input  dispatch_valid, dispatch_id, dispatch_instr,
        input  drop_valid, drop_id, commit_miss
    );

    // Scoreboard side.
    modport slave (
        input  alloc_valid, alloc_id, alloc_instr,
        input  commit_valid, commit_id, commit_kill,
        input  dispatch_ready,
        output alloc_ready,
        output dispatch_valid, dispatch_id, dispatch_instr,
        output drop_valid, drop_id, commit_miss
    );

endinterface

// File: rtl/rvfpm_commit_scoreboard.sv
// Holds issued FPU instructions until commit/kill; releases committed ones in order, retires killed ones.
// Latency: alloc+commit to dispatch_valid 1 cycle; killed head dropped 1 cycle after the kill edge.
// Backpressure: alloc_ready=!full (no same-cycle pop credit); head held while dispatch_ready=0.
// Optional RVFPM_SCB_STATS_EN adds dispatch/kill event counters; otherwise stat_* are tied to 0.
module rvfpm_commit_scoreboard
    import pa_rvfpm::*;
#(
    parameter int QUEUE_DEPTH = SCB_QUEUE_DEPTH,
    parameter int X_ID_WIDTH  = SCB_ID_W
) (
    input  logic                         ck,
    input  logic                         rst,
    rvfpm_commit_scoreboard_if.slave     xif,
    output logic [$clog2(QUEUE_DEPTH):0] count,
    output logic [31:0]                  stat_dispatched,
    output logic [31:0]                  stat_killed
);

    localparam int IDX_W = $clog2(QUEUE_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    scb_entry_t             q [QUEUE_DEPTH];
    ptr_t                   head_ptr;
    ptr_t                   tail_ptr;
    logic [IDX_W-1:0]       head_idx;
    logic [IDX_W-1:0]       tail_idx;
    logic                   full;
    logic                   alloc_fire;

    scb_entry_t             head_q;
    logic                   disp_vld;
    logic                   disp_fire;
    logic                   drop_fire;
    logic                   pop;

    logic [IDX_W-1:0]       scan_idx;
    logic                   match_old;
    int                     match_k;
    logic                   match_new;
    logic                   commit_hit;
    logic                   new_committed;
    logic                   new_killed;
    logic [QUEUE_DEPTH-1:0] commit_mask;
    logic [QUEUE_DEPTH-1:0] kill_mask;

    logic                   drop_vld_q;
    logic [X_ID_WIDTH-1:0]  drop_id_q;
    logic                   miss_q;

    assign head_idx   = head_ptr[IDX_W-1:0];
    assign tail_idx   = tail_ptr[IDX_W-1:0];
    assign full       = (head_ptr[IDX_W] != tail_ptr[IDX_W]) && (head_idx == tail_idx);
    assign alloc_fire = xif.alloc_valid && !full;
    assign count      = tail_ptr - head_ptr;

    // Head decode: everything on the dispatch side comes from stored state only.
    assign head_q    = q[head_idx];
    assign disp_vld  = head_q.valid && head_q.committed && !head_q.killed;
    assign disp_fire = disp_vld && xif.dispatch_ready;
    assign drop_fire = head_q.valid && head_q.killed;
    assign pop       = disp_fire || drop_fire;

    assign xif.alloc_ready    = !full;
    assign xif.dispatch_valid = disp_vld;
    assign xif.dispatch_id    = X_ID_WIDTH'(head_q.id);
    assign xif.dispatch_instr = head_q.instr;
    assign xif.drop_valid     = drop_vld_q;
    assign xif.drop_id        = drop_id_q;
    assign xif.commit_miss    = miss_q;

    // Commit matching: priority scan from the head for the oldest uncommitted
    // id match, then a kill mask covering it and everything younger. A
    // same-cycle allocation is the youngest candidate. The popping head is
    // already committed, so a kill can never cover it.
    always_comb begin
        scan_idx    = '0;
        match_old   = 1'b0;
        match_k     = 0;
        commit_mask = '0;
        kill_mask   = '0;
        for (int k = 0; k < QUEUE_DEPTH; k++) begin
            scan_idx = head_idx + IDX_W'(k);
            if (xif.commit_valid && !match_old && q[scan_idx].valid &&
                !q[scan_idx].committed &&
                (X_ID_WIDTH'(q[scan_idx].id) == xif.commit_id)) begin
                match_old             = 1'b1;
                match_k               = k;
                commit_mask[scan_idx] = 1'b1;
            end
        end
        for (int k = 0; k < QUEUE_DEPTH; k++) begin
            scan_idx = head_idx + IDX_W'(k);
            if (match_old && xif.commit_kill && (k >= match_k) && q[scan_idx].valid) begin
                commit_mask[scan_idx] = 1'b1;
                kill_mask[scan_idx]   = 1'b1;
            end
        end
        match_new     = xif.commit_valid && !match_old && alloc_fire &&
                        (xif.alloc_id == xif.commit_id);
        commit_hit    = match_old || match_new;
        new_committed = match_new || (match_old && xif.commit_kill);
        new_killed    = xif.commit_kill && commit_hit;
    end

    // Entry storage: pop clears the head, allocation writes the tail, and
    // commit/kill masks update everything else.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (pop && (IDX_W'(i) == head_idx)) begin
                    q[i].valid <= 1'b0;
                end else if (alloc_fire && (IDX_W'(i) == tail_idx)) begin
                    q[i] <= '{valid:     1'b1,
                              committed: new_committed,
                              killed:    new_killed,
                              id:        SCB_ID_W'(xif.alloc_id),
                              instr:     xif.alloc_instr};
                end else begin
                    if (commit_mask[i]) q[i].committed <= 1'b1;
                    if (kill_mask[i])   q[i].killed    <= 1'b1;
                end
            end
        end
    end

    // Head/tail pointers wrap modulo twice the depth.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
        end else begin
            if (pop)        head_ptr <= head_ptr + ptr_t'(1);
            if (alloc_fire) tail_ptr <= tail_ptr + ptr_t'(1);
        end
    end

    // Registered event pulses: drop report and unmatched commit.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            drop_vld_q <= 1'b0;
            drop_id_q  <= '0;
            miss_q     <= 1'b0;
        end else begin
            drop_vld_q <= drop_fire;
            if (drop_fire) drop_id_q <= X_ID_WIDTH'(head_q.id);
            miss_q     <= xif.commit_valid && !commit_hit;
        end
    end

`ifdef RVFPM_SCB_STATS_EN
    logic [31:0] stat_disp_q;
    logic [31:0] stat_kill_q;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            stat_disp_q <= '0;
            stat_kill_q <= '0;
        end else begin
            if (disp_fire) stat_disp_q <= stat_disp_q + 32'd1;
            if (drop_fire) stat_kill_q <= stat_kill_q + 32'd1;
        end
    end

    assign stat_dispatched = stat_disp_q;
    assign stat_killed     = stat_kill_q;
`else
    assign stat_dispatched = '0;
    assign stat_killed     = '0;
`endif

endmodule

// File: tb/tb_rvfpm_commit_scoreboard.sv
// Directed bench for the FPU commit scoreboard.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Backpressure: dispatch_ready driven explicitly per scenario.
module tb_rvfpm_commit_scoreboard;

    logic        ck;
    logic        rst;
    logic [2:0]  count;
    logic [31:0] stat_dispatched;
    logic [31:0] stat_killed;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_disp = 0;
    int exp_kill = 0;

    rvfpm_commit_scoreboard_if #(.X_ID_WIDTH(4)) xif ();

    rvfpm_commit_scoreboard #(
        .QUEUE_DEPTH (4),
        .X_ID_WIDTH  (4)
    ) dut (
        .ck              (ck),
        .rst             (rst),
        .xif             (xif.slave),
        .count           (count),
        .stat_dispatched (stat_dispatched),
        .stat_killed     (stat_killed)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic idle();
        xif.alloc_valid    = 1'b0;
        xif.alloc_id       = '0;
        xif.alloc_instr    = '0;
        xif.commit_valid   = 1'b0;
        xif.commit_id      = '0;
        xif.commit_kill    = 1'b0;
        xif.dispatch_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        #3;
        n_cmp++; if (xif.alloc_ready !== 1'b1) begin n_bad++; $display("FAIL rst_alloc_ready got=%b exp=1", xif.alloc_ready); end
        n_cmp++; if (xif.dispatch_valid !== 1'b0) begin n_bad++; $display("FAIL rst_dispatch_valid got=%b exp=0", xif.dispatch_valid); end
        n_cmp++; if (xif.dispatch_id !== 4'd0) begin n_bad++; $display("FAIL rst_dispatch_id got=%0d exp=0", xif.dispatch_id); end
        n_cmp++; if (xif.dispatch_instr !== 32'd0) begin n_bad++; $display("FAIL rst_dispatch_instr got=%h exp=0", xif.dispatch_instr); end
        n_cmp++; if (xif.drop_valid !== 1'b0 || xif.drop_id !== 4'd0) begin n_bad++; $display("FAIL rst_drop got=%b/%0d exp=0/0", xif.drop_valid, xif.drop_id); end
        n_cmp++; if (xif.commit_miss !== 1'b0) begin n_bad++; $display("FAIL rst_commit_miss got=%b exp=0", xif.commit_miss); end
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rst_count got=%0d exp=0", count); end
        n_cmp++; if (stat_dispatched !== 32'd0 || stat_killed !== 32'd0) begin n_bad++; $display("FAIL rst_stats got=%0d/%0d exp=0/0", stat_dispatched, stat_killed); end
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_in_order();
        idle();
        for (int i = 1; i <= 3; i++) begin
            xif.alloc_valid = 1'b1;
            xif.alloc_id    = 4'(i);
            xif.alloc_instr = 32'h0000_1000 + 32'(i);
            tick();
            n_cmp++; if (count !== 3'(i)) begin n_bad++; $display("FAIL order_alloc_count got=%0d exp=%0d", count, i); end
            n_cmp++; if (xif.dispatch_valid !== 1'b0) begin n_bad++; $display("FAIL order_no_dispatch got=%b exp=0", xif.dispatch_valid); end
        end
        idle();
        tick();
        n_cmp++; if (xif.dispatch_valid !== 1'b0 || count !== 3'd3) begin n_bad++; $display("FAIL order_idle got=%b/%0d exp=0/3", xif.dispatch_valid, count); end
        xif.dispatch_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            xif.commit_valid = 1'b1;
            xif.commit_id    = 4'(i);
            tick();
            n_cmp++; if (xif.dispatch_valid !== 1'b1 || xif.dispatch_id !== 4'(i)) begin n_bad++; $display("FAIL order_dispatch got=%b/%0d exp=1/%0d", xif.dispatch_valid, xif.dispatch_id, i); end
            n_cmp++; if (xif.dispatch_instr !== 32'h0000_1000 + 32'(i)) begin n_bad++; $display("FAIL order_instr got=%h exp=%h", xif.dispatch_instr, 32'h0000_1000 + 32'(i)); end
            n_cmp++; if (count !== 3'(4 - i)) begin n_bad++; $display("FAIL order_count got=%0d exp=%0d", count, 4 - i); end
            if (i > 1) exp_disp++;
        end
        xif.commit_valid = 1'b0;
        tick();
        exp_disp++;
        n_cmp++; if (xif.dispatch_valid !== 1'b0 || count !== 3'd0) begin n_bad++; $display("FAIL order_drained got=%b/%0d exp=0/0", xif.dispatch_valid, count); end
        idle();
    endtask

    task automatic test_full_wrap();
        idle();
        for (int i = 0; i < 4; i++) begin
            xif.alloc_valid = 1'b1;
            xif.alloc_id    = 4'(i);
            xif.alloc_instr = 32'h0000_2000 + 32'(i);
            tick();
        end
        xif.alloc_valid = 1'b0;
        n_cmp++; if (xif.alloc_ready !== 1'b0 || count !== 3'd4) begin n_bad++; $display("FAIL full_ready got=%b/%0d exp=0/4", xif.alloc_ready, count); end
        xif.commit_valid   = 1'b1;
        xif.commit_id      = 4'd0;
        xif.dispatch_ready = 1'b1;
        tick();
        xif.commit_valid = 1'b0;
        n_cmp++; if (xif.dispatch_valid !== 1'b1 || xif.dispatch_id !== 4'd0 || xif.alloc_ready !== 1'b0) begin n_bad++; $display("FAIL full_commit0 got=%b/%0d/%b exp=1/0/0", xif.dispatch_valid, xif.dispatch_id, xif.alloc_ready); end
        tick();
        exp_disp++;
        xif.dispatch_ready = 1'b0;
        n_cmp++; if (xif.alloc_ready !== 1'b1 || count !== 3'd3) begin n_bad++; $display("FAIL full_after_pop got=%b/%0d exp=1/3", xif.alloc_ready, count); end
        xif.alloc_valid = 1'b1;
        xif.alloc_id    = 4'd4;
        xif.alloc_instr = 32'h0000_2004;
        tick();
        xif.alloc_valid = 1'b0;
        n_cmp++; if (xif.alloc_ready !== 1'b0 || count !== 3'd4 || xif.dispatch_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_alloc got=%b/%0d/%b exp=0/4/0", xif.alloc_ready, count, xif.dispatch_valid); end
        xif.commit_valid = 1'b1;
        xif.commit_id    = 4'd1;
        xif.commit_kill  = 1'b1;
        tick();
        xif.commit_valid = 1'b0;
        xif.commit_kill  = 1'b0;
        n_cmp++; if (xif.drop_valid !== 1'b0 || xif.dispatch_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_kill_edge got=%b/%b exp=0/0", xif.drop_valid, xif.dispatch_valid); end
        for (int j = 1; j <= 4; j++) begin
            tick();
            exp_kill++;
            n_cmp++; if (xif.drop_valid !== 1'b1 || xif.drop_id !== 4'(j)) begin n_bad++; $display("FAIL wrap_drop got=%b/%0d exp=1/%0d", xif.drop_valid, xif.drop_id, j); end
        end
        tick();
        n_cmp++; if (xif.drop_valid !== 1'b0 || count !== 3'd0) begin n_bad++; $display("FAIL wrap_drained got=%b/%0d exp=0/0", xif.drop_valid, count); end
        idle();
    endtask

    task automatic test_hold_kill();
        idle();
        for (int i = 5; i <= 7; i++) begin
            xif.alloc_valid = 1'b1;
            xif.alloc_id    = 4'(i);
            xif.alloc_instr = 32'h0000_3000 + 32'(i);
            tick();
        end
        xif.alloc_valid  = 1'b0;
        xif.commit_valid = 1'b1;
        xif.commit_id    = 4'd5;
        tick();
        xif.commit_id    = 4'd6;
        xif.commit_kill  = 1'b1;
        tick();
        xif.commit_valid = 1'b0;
        xif.commit_kill  = 1'b0;
        n_cmp++; if (xif.dispatch_valid !== 1'b1 || xif.dispatch_id !== 4'd5 || xif.drop_valid !== 1'b0) begin n_bad++; $display("FAIL hold_after_kill got=%b/%0d/%b exp=1/5/0", xif.dispatch_valid, xif.dispatch_id, xif.drop_valid); end
        for (int j = 0; j < 2; j++) begin
            tick();
            n_cmp++; if (xif.dispatch_valid !== 1'b1 || xif.dispatch_id !== 4'd5 || xif.dispatch_instr !== 32'h0000_3005) begin n_bad++; $display("FAIL hold_stable got=%b/%0d/%h exp=1/5/00003005", xif.dispatch_valid, xif.dispatch_id, xif.dispatch_instr); end
            n_cmp++; if (xif.drop_valid !== 1'b0 || count !== 3'd3) begin n_bad++; $display("FAIL hold_no_drop got=%b/%0d exp=0/3", xif.drop_valid, count); end
        end
        xif.dispatch_ready = 1'b1;
        tick();
        exp_disp++;
        n_cmp++; if (xif.dispatch_valid !== 1'b0 || xif.drop_valid !== 1'b0 || count !== 3'd2) begin n_bad++; $display("FAIL hold_pop5 got=%b/%b/%0d exp=0/0/2", xif.dispatch_valid, xif.drop_valid, count); end
        tick();
        exp_kill++;
        n_cmp++; if (xif.drop_valid !== 1'b1 || xif.drop_id !== 4'd6 || count !== 3'd1) begin n_bad++; $display("FAIL hold_drop6 got=%b/%0d/%0d exp=1/6/1", xif.drop_valid, xif.drop_id, count); end
        tick();
        exp_kill++;
        n_cmp++; if (xif.drop_valid !== 1'b1 || xif.drop_id !== 4'd7 || count !== 3'd0) begin n_bad++; $display("FAIL hold_drop7 got=%b/%0d/%0d exp=1/7/0", xif.drop_valid, xif.drop_id, count); end
        tick();
        n_cmp++; if (xif.drop_valid !== 1'b0) begin n_bad++; $display("FAIL hold_drop_end got=%b exp=0", xif.drop_valid); end
`ifdef RVFPM_SCB_STATS_EN
        n_cmp++; if (stat_killed !== 32'(exp_kill) || stat_dispatched !== 32'(exp_disp)) begin n_bad++; $display("FAIL hold_stats got=%0d/%0d exp=%0d/%0d", stat_dispatched, stat_killed, exp_disp, exp_kill); end
`else
        n_cmp++; if (stat_killed !== 32'd0 || stat_dispatched !== 32'd0) begin n_bad++; $display("FAIL hold_stats_off got=%0d/%0d exp=0/0", stat_dispatched, stat_killed); end
`endif
        idle();
    endtask

    task automatic test_same_cycle();
        idle();
        xif.alloc_valid  = 1'b1;
        xif.alloc_id     = 4'd9;
        xif.alloc_instr  = 32'h0000_4009;
        xif.commit_valid = 1'b1;
        xif.commit_id    = 4'd9;
        tick();
        idle();
        n_cmp++; if (xif.dispatch_valid !== 1'b1 || xif.dispatch_id !== 4'd9 || xif.dispatch_instr !== 32'h0000_4009) begin n_bad++; $display("FAIL same_cycle got=%b/%0d/%h exp=1/9/00004009", xif.dispatch_valid, xif.dispatch_id, xif.dispatch_instr); end
        xif.dispatch_ready = 1'b1;
        tick();
        exp_disp++;
        n_cmp++; if (xif.dispatch_valid !== 1'b0 || count !== 3'd0) begin n_bad++; $display("FAIL same_cycle_pop got=%b/%0d exp=0/0", xif.dispatch_valid, count); end
        idle();
    endtask

    task automatic test_miss();
        idle();
        xif.alloc_valid = 1'b1;
        xif.alloc_id    = 4'd2;
        xif.alloc_instr = 32'h0000_5002;
        tick();
        idle();
        xif.commit_valid = 1'b1;
        xif.commit_id    = 4'hA;
        tick();
        idle();
        n_cmp++; if (xif.commit_miss !== 1'b1 || count !== 3'd1) begin n_bad++; $display("FAIL miss_pulse got=%b/%0d exp=1/1", xif.commit_miss, count); end
        tick();
        n_cmp++; if (xif.commit_miss !== 1'b0 || count !== 3'd1 || xif.dispatch_valid !== 1'b0) begin n_bad++; $display("FAIL miss_end got=%b/%0d/%b exp=0/1/0", xif.commit_miss, count, xif.dispatch_valid); end
    endtask

    task automatic test_reset_midflight();
        idle();
        for (int i = 3; i <= 4; i++) begin
            xif.alloc_valid = 1'b1;
            xif.alloc_id    = 4'(i);
            xif.alloc_instr = 32'h0000_6000 + 32'(i);
            tick();
        end
        idle();
        xif.commit_valid = 1'b1;
        xif.commit_id    = 4'd2;
        tick();
        idle();
        n_cmp++; if (count !== 3'd3 || xif.dispatch_valid !== 1'b1 || xif.dispatch_id !== 4'd2) begin n_bad++; $display("FAIL mid_pre got=%0d/%b/%0d exp=3/1/2", count, xif.dispatch_valid, xif.dispatch_id); end
        #2;
        rst = 1'b0;
        #1;
        exp_disp = 0;
        exp_kill = 0;
        n_cmp++; if (count !== 3'd0 || xif.alloc_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_count got=%0d/%b exp=0/1", count, xif.alloc_ready); end
        n_cmp++; if (xif.dispatch_valid !== 1'b0 || xif.dispatch_id !== 4'd0 || xif.dispatch_instr !== 32'd0) begin n_bad++; $display("FAIL mid_rst_dispatch got=%b/%0d/%h exp=0/0/0", xif.dispatch_valid, xif.dispatch_id, xif.dispatch_instr); end
        n_cmp++; if (xif.drop_valid !== 1'b0 || xif.drop_id !== 4'd0 || xif.commit_miss !== 1'b0) begin n_bad++; $display("FAIL mid_rst_pulses got=%b/%0d/%b exp=0/0/0", xif.drop_valid, xif.drop_id, xif.commit_miss); end
        n_cmp++; if (stat_dispatched !== 32'd0 || stat_killed !== 32'd0) begin n_bad++; $display("FAIL mid_rst_stats got=%0d/%0d exp=0/0", stat_dispatched, stat_killed); end
        tick();
        rst = 1'b1;
        tick();
        xif.alloc_valid  = 1'b1;
        xif.alloc_id     = 4'd5;
        xif.alloc_instr  = 32'h0000_7005;
        xif.commit_valid = 1'b1;
        xif.commit_id    = 4'd5;
        tick();
        idle();
        n_cmp++; if (xif.dispatch_valid !== 1'b1 || xif.dispatch_id !== 4'd5 || count !== 3'd1) begin n_bad++; $display("FAIL mid_post got=%b/%0d/%0d exp=1/5/1", xif.dispatch_valid, xif.dispatch_id, count); end
        xif.dispatch_ready = 1'b1;
        tick();
        exp_disp++;
        idle();
        n_cmp++; if (count !== 3'd0 || xif.dispatch_valid !== 1'b0) begin n_bad++; $display("FAIL mid_post_pop got=%0d/%b exp=0/0", count, xif.dispatch_valid); end
`ifdef RVFPM_SCB_STATS_EN
        n_cmp++; if (stat_dispatched !== 32'(exp_disp) || stat_killed !== 32'(exp_kill)) begin n_bad++; $display("FAIL mid_stats got=%0d/%0d exp=%0d/%0d", stat_dispatched, stat_killed, exp_disp, exp_kill); end
`else
        n_cmp++; if (stat_dispatched !== 32'd0 || stat_killed !== 32'd0) begin n_bad++; $display("FAIL mid_stats_off got=%0d/%0d exp=0/0", stat_dispatched, stat_killed); end
`endif
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full_wrap();
        test_hold_kill();
        test_same_cycle();
        test_miss();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
